// File: rtl/brk_hit_scheduler_if.sv
// Handshake bundle between the collision requesters, the brick rows and brk_hit_scheduler.
// slave = scheduler side, master = requesters/rows (or a bench standing in for them).
interface brk_hit_scheduler_if #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_ROWS = 4,
  parameter int ROW_W    = 2,
  parameter int SCORE_W  = 16,
  parameter int LEVEL_W  = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*ROW_W-1:0] req_row;
  logic [NUM_REQ*3-1:0]     req_brk;
  logic [NUM_ROWS-1:0]      row_scores;
  logic [NUM_ROWS-1:0]      row_empty;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_ROWS-1:0]      row_sel;
  logic [2:0]               brk_num;
  logic                     hit_valid;
  logic                     hit_result;
  logic [SCORE_W-1:0]       score;
  logic [LEVEL_W-1:0]       level;
  logic                     no_brks;
  logic                     busy;

  modport slave (
    input  req, req_row, req_brk, row_scores, row_empty,
    output gnt, row_sel, brk_num, hit_valid, hit_result, score, level, no_brks, busy
  );

  modport master (
    output req, req_row, req_brk, row_scores, row_empty,
    input  gnt, row_sel, brk_num, hit_valid, hit_result, score, level, no_brks, busy
  );
endinterface

// File: rtl/brk_hit_scheduler.sv
// Round-robin hit scheduler for the brick rows: one hit per pass, saturating score, delayed refill.
// Optional macro BRK_SCORE_LEVEL_MULT_EN: a destroyed brick scores (level+1) instead of 1.
//
// state  | meaning
// IDLE   | waiting for a request; grants one at the edge leaving IDLE
// ISSUE  | row strobe and brick index presented to the rows
// CHECK  | sample the addressed row's score pulse, report the hit
// REFILL | all rows empty: count down, then pulse no_brks and bump level
module brk_hit_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_ROWS     = 4,
  parameter int ROW_W        = 2,
  parameter int SCORE_W      = 16,
  parameter int LEVEL_W      = 4,
  parameter int REFILL_DELAY = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  brk_hit_scheduler_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (REFILL_DELAY > 1) ? $clog2(REFILL_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFILL_DELAY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, REFILL} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_ROWS-1:0] row_sel_q, row_sel_d;
  logic [2:0]          brk_num_q, brk_num_d;
  logic                hit_valid_q, hit_valid_d;
  logic                hit_result_q, hit_result_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                no_brks_q, no_brks_d;
  logic                busy_q;

  logic                found;
  logic [PTR_W-1:0]    win;
  int                  idx;
  logic [ROW_W-1:0]    win_row;
  logic [2:0]          win_brk;
  logic                hit_sample;
  logic [SCORE_W:0]    score_inc, score_sum;

  // first active requester at or after the pointer, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    win_row = bus.req_row[int'(win)*ROW_W +: ROW_W];
    win_brk = bus.req_brk[int'(win)*3 +: 3];
  end

  // out-of-range rows never match, so they sample as a miss
  always_comb begin
    hit_sample = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_q == ROW_W'(r)) hit_sample = bus.row_scores[r];
    end
  end

  always_comb begin
`ifdef BRK_SCORE_LEVEL_MULT_EN
    score_inc = (SCORE_W+1)'(level_q) + (SCORE_W+1)'(1);
`else
    score_inc = (SCORE_W+1)'(1);
`endif
    score_sum = {1'b0, score_q} + score_inc;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    row_sel_d    = '0;
    brk_num_d    = '0;
    hit_valid_d  = 1'b0;
    hit_result_d = 1'b0;
    score_d      = score_q;
    level_d      = level_q;
    no_brks_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d     = NUM_REQ'(1) << win;
          brk_num_d = win_brk;
          row_d     = win_row;
          for (int r = 0; r < NUM_ROWS; r++) row_sel_d[r] = (win_row == ROW_W'(r));
          ptr_d     = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        hit_valid_d  = 1'b1;
        hit_result_d = hit_sample;
        if (hit_sample) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (&bus.row_empty) begin
          state_d = REFILL;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (cnt_q == '0) begin
          no_brks_d = 1'b1;
          level_d   = level_q + 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      row_sel_q    <= '0;
      brk_num_q    <= '0;
      hit_valid_q  <= 1'b0;
      hit_result_q <= 1'b0;
      score_q      <= '0;
      level_q      <= '0;
      no_brks_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      row_sel_q    <= row_sel_d;
      brk_num_q    <= brk_num_d;
      hit_valid_q  <= hit_valid_d;
      hit_result_q <= hit_result_d;
      score_q      <= score_d;
      level_q      <= level_d;
      no_brks_q    <= no_brks_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.row_sel    = row_sel_q;
  assign bus.brk_num    = brk_num_q;
  assign bus.hit_valid  = hit_valid_q;
  assign bus.hit_result = hit_result_q;
  assign bus.score      = score_q;
  assign bus.level      = level_q;
  assign bus.no_brks    = no_brks_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/brk_hit_scheduler.md
Name: brk_hit_scheduler

Overview:
Sequences ball-collision hit requests into the brick row array, one hit at a time.
- Arbitrates round-robin among NUM_REQ collision sources.
- Drives a one-hot row strobe and a brick index into the row controllers, then samples each row's score pulse.
- Keeps a saturating score and a level counter.
- Issues a delayed refill pulse (no_brks) when every row is empty.

Parameters:
NUM_REQ, 2, number of collision requesters
NUM_ROWS, 4, number of brick row controllers
ROW_W, 2, width of a requested row index
SCORE_W, 16, score counter width
LEVEL_W, 4, level counter width
REFILL_DELAY, 8, cycles between all-empty detection and the no_brks pulse (minimum 1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  NUM_REQ  per-requester hit request; held high until granted
req_row  in  NUM_REQ*ROW_W  packed row index, requester i at [i*ROW_W +: ROW_W]
req_brk  in  NUM_REQ*3  packed brick index 0-7, requester i at [i*3 +: 3]
row_scores  in  NUM_ROWS  per-row one-cycle "brick destroyed" pulse from the rows
row_empty  in  NUM_ROWS  per-row all-bricks-gone flag
gnt  out  NUM_REQ  one-hot, one-cycle grant
row_sel  out  NUM_ROWS  one-hot row strobe to the rows
brk_num  out  3  brick index to the rows
hit_valid  out  1  one-cycle pulse: hit result available
hit_result  out  1  1 = brick destroyed, 0 = miss or brick already gone
score  out  SCORE_W  accumulated score
level  out  LEVEL_W  current level
no_brks  out  1  one-cycle refill pulse to all rows
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - gnt, row_sel, hit_valid, hit_result, no_brks, busy = 0.
  - brk_num, score, level = 0.
  - Round-robin pointer = 0.
- All outputs are registered.
- States: IDLE, ISSUE, CHECK, REFILL.
- IDLE:
  - If any req is high, grant the first active requester at or after the pointer, wrapping around.
  - At that edge: gnt[i]=1 for one cycle; brk_num=req_brk[i]; row_sel=one-hot(req_row[i]); pointer=(i+1) mod NUM_REQ; go to ISSUE.
  - If req_row[i] >= NUM_ROWS: row_sel=0, and the request still proceeds through ISSUE and CHECK.
  - If no req is high, stay in IDLE.
- ISSUE: row_sel and brk_num are held for exactly this one cycle. Next state CHECK; row_sel cleared at that edge.
- CHECK: sample row_scores[row] (0 for an out-of-range row).
  - At that edge: hit_valid=1 and hit_result=sample, both for one cycle.
  - If the sample is 1, score += 1, saturating at all-ones.
  - If &row_empty is 1 in this cycle, go to REFILL with the delay counter loaded to REFILL_DELAY-1; otherwise go to IDLE.
- REFILL:
  - Count down each cycle.
  - At zero: no_brks=1 for one cycle, level += 1 (wraps modulo 2^LEVEL_W), return to IDLE.
- Latency:
  - req sampled in cycle n → gnt and row_sel in n+1 → hit_valid in n+3 → next grant possible at the edge ending n+3.
  - Peak throughput: one hit per 3 cycles.
- req is ignored outside IDLE; requesters must hold req until gnt.
- Simultaneous requests: only one grant per pass; the loser is granted on the next IDLE visit.
- A req deasserted before grant is dropped with no side effects.
- Reset mid-operation: everything returns to reset values immediately, including an in-flight hit (no hit_valid) and a pending refill (no no_brks). Score and level are lost.

Optional Feature:
BRK_SCORE_LEVEL_MULT_EN
- Defined: a destroyed brick adds (level+1), zero-extended to SCORE_W, to score, still saturating.
- Undefined: every destroyed brick adds exactly 1.

Test Plan:
- Reset then single hit: req[0]=1, row 2, brick 5, row_scores[2] pulses in CHECK → gnt[0] next cycle, row_sel=0100 and brk_num=5 for one cycle, hit_valid with hit_result=1 two cycles later, score=1.
- Contention: req=11 held continuously → grants alternate 01,10,01,10; req[0] deasserted after its grant → only gnt[1] continues.
- Miss / out-of-range: row_scores stays 0 → hit_result=0, score unchanged. NUM_ROWS=3 with req_row=3 → row_sel=000, hit_result=0.
- Refill: row_empty=1111 during a CHECK with a hit → exactly REFILL_DELAY cycles later no_brks pulses once, level 0→1, busy stays high throughout, and req is not granted until back in IDLE.
- Saturation and wrap: score preset near max by repeated hits with SCORE_W=4 → sticks at 15; LEVEL_W=2 with 4 refills → level wraps to 0. With BRK_SCORE_LEVEL_MULT_EN and level=2, a hit adds 3.
- Asynchronous reset asserted during ISSUE and during REFILL → outputs clear without a clock edge; no hit_valid or no_brks is produced afterwards.
